// File: rtl/apb_quad_gen.sv
// ---------------------------------------------------------------------------
// apb_quad_gen -- APB-mapped quadrature pulse generator.
//
// Emits a programmed number of A/B quadrature edges at a programmable rate
// and direction, and keeps a signed position count. It is the transmit side
// of the on-chip quadrature decoder: forward steps count +1 on the decoder,
// reverse steps count -1.
//
// Register map (byte offsets):
//   0x00 CTRL   [0] start (w1s, self-clears)  [1] stop_req (w1s, self-clears)
//               [2] cont  [3] dir (1=reverse)  [4] irq_en  [31:16] div
//   0x04 STAT   [0] busy  [1] done (sticky, write 0 to bit1 to clear)
//   0x08 STEPS  edge count per run
//   0x0C POS    signed position
//   0x10 REMAIN edges left in the current run (read-only)
//   other offsets read 0
//
// Ports:
//   apb_clock, resetn        clock, asynchronous active-low reset
//   stop                     debug halt, freezes divider and stepping
//   apb_psel .. apb_pwdata   APB slave inputs, no wait states
//   apb_prdata               registered read data
//   quad_a, quad_b           registered quadrature outputs
//   busy                     high while a run is in progress
//   irq                      done & irq_en, registered (QGEN_IRQ_EN only)
//
// Build option: define QGEN_IRQ_EN to add the irq port and CTRL[4].
//
// State table:
//   state  | meaning
//   IDLE   | outputs hold, waiting for start
//   RUN    | divider running, one quadrature edge every div+1 clocks
// ---------------------------------------------------------------------------
module apb_quad_gen #(
    parameter int DIV_BITS = 16,
    parameter int CNT_BITS = 32
) (
    input  logic        apb_clock,
    input  logic        resetn,
    input  logic        stop,
    input  logic        apb_psel,
    input  logic        apb_penable,
    input  logic        apb_pwrite,
    input  logic [11:0] apb_paddr,
    input  logic [31:0] apb_pwdata,
    output logic [31:0] apb_prdata,
    output logic        quad_a,
    output logic        quad_b,
`ifdef QGEN_IRQ_EN
    output logic        irq,
`endif
    output logic        busy
);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
    localparam logic [DIV_BITS-1:0] DIV_ONE = DIV_BITS'(1);

    state_t                r_state;
    state_t                w_state_next;

    logic                  r_start;
    logic                  r_stop_req;
    logic                  r_cont;
    logic                  r_dir;
    logic [DIV_BITS-1:0]   r_div;
    logic                  r_done;
    logic [CNT_BITS-1:0]   r_steps;
    logic [CNT_BITS-1:0]   r_pos;
    logic [CNT_BITS-1:0]   r_remain;
    logic [DIV_BITS-1:0]   r_divcnt;
    logic [1:0]            r_ph;
    logic                  r_quad_a;
    logic                  r_quad_b;
    logic [31:0]           r_prdata;
`ifdef QGEN_IRQ_EN
    logic                  r_irq_en;
    logic                  r_irq;
`endif

    logic                  w_busy;
    logic                  w_wr;
    logic                  w_rd_setup;
    logic                  w_wr_ctrl;
    logic                  w_wr_stat;
    logic                  w_wr_steps;
    logic                  w_wr_pos;
    logic                  w_begin;
    logic                  w_zero_start;
    logic                  w_abort;
    logic                  w_step;
    logic                  w_last;
    logic                  w_reload;
    logic                  w_finish;
    logic [1:0]            w_ph_adv;
    logic [31:0]           w_rdata;
    logic                  w_unused;

    // ---------------- APB decode ----------------
    assign w_wr       = apb_psel && apb_penable && apb_pwrite;
    assign w_rd_setup = apb_psel && !apb_penable && !apb_pwrite;
    assign w_wr_ctrl  = w_wr && (apb_paddr == 12'h000);
    assign w_wr_stat  = w_wr && (apb_paddr == 12'h004);
    assign w_wr_steps = w_wr && (apb_paddr == 12'h008);
    assign w_wr_pos   = w_wr && (apb_paddr == 12'h00C);

`ifdef QGEN_IRQ_EN
    assign w_unused = ^apb_pwdata[15:5];
`else
    assign w_unused = ^apb_pwdata[15:4];
`endif

    // ---------------- run control ----------------
    assign w_begin      = (r_state == S_IDLE) && r_start && (r_steps != '0);
    assign w_zero_start = (r_state == S_IDLE) && r_start && (r_steps == '0);
    // A pending stop_req wins over a step landing in the same cycle, so
    // REMAIN and the outputs freeze exactly where the request found them.
    assign w_abort      = (r_state == S_RUN) && r_stop_req;
    assign w_step       = (r_state == S_RUN) && !r_stop_req && !stop &&
                          (r_divcnt == '0);
    assign w_last       = w_step && (r_remain == CNT_ONE);
    assign w_reload     = w_last && r_cont && (r_steps != '0);
    assign w_finish     = w_last && !w_reload;
    assign w_ph_adv     = r_dir ? (r_ph - 2'd1) : (r_ph + 2'd1);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge apb_clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_begin)              w_state_next = S_RUN;
            S_RUN:   if (w_abort || w_finish)  w_state_next = S_IDLE;
            default:                           w_state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_busy = (r_state == S_RUN);
    end

    // ---------------- registers and datapath ----------------
    always_ff @(posedge apb_clock or negedge resetn) begin
        if (!resetn) begin
            r_start    <= 1'b0;
            r_stop_req <= 1'b0;
            r_cont     <= 1'b0;
            r_dir      <= 1'b0;
            r_div      <= '0;
            r_done     <= 1'b0;
            r_steps    <= '0;
            r_pos      <= '0;
            r_remain   <= '0;
            r_divcnt   <= '0;
            r_ph       <= 2'd0;
            r_quad_a   <= 1'b0;
            r_quad_b   <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_cont <= apb_pwdata[2];
                r_dir  <= apb_pwdata[3];
                r_div  <= apb_pwdata[16 +: DIV_BITS];
            end

            // start is ignored while running; it stays set for the whole run
            if (w_wr_ctrl && apb_pwdata[0] && (r_state == S_IDLE)) begin
                r_start <= 1'b1;
            end else if (w_finish || w_abort || w_zero_start) begin
                r_start <= 1'b0;
            end

            // one-cycle pulse: acts in RUN, simply lapses in IDLE
            r_stop_req <= w_wr_ctrl && apb_pwdata[1];

            if (w_finish || w_zero_start) begin
                r_done <= 1'b1;
            end else if (w_wr_stat && !apb_pwdata[1]) begin
                r_done <= 1'b0;
            end

            if (w_wr_steps) begin
                r_steps <= apb_pwdata[CNT_BITS-1:0];
            end

            if (w_wr_pos) begin
                r_pos <= apb_pwdata[CNT_BITS-1:0];
            end else if (w_step) begin
                r_pos <= r_dir ? (r_pos - CNT_ONE) : (r_pos + CNT_ONE);
            end

            if (w_begin) begin
                r_remain <= r_steps;
            end else if (w_step) begin
                r_remain <= w_reload ? r_steps : (r_remain - CNT_ONE);
            end

            // Down-counter reloaded from div at every step, so a div change
            // only shapes whole periods and can never be overrun.
            if (w_begin) begin
                r_divcnt <= r_div;
            end else if ((r_state == S_RUN) && !stop) begin
                r_divcnt <= (r_divcnt == '0) ? r_div : (r_divcnt - DIV_ONE);
            end

            // ph -> {A,B}: 0->00 1->10 2->11 3->01, i.e. A = ph0^ph1, B = ph1
            if (w_step) begin
                r_ph     <= w_ph_adv;
                r_quad_a <= w_ph_adv[0] ^ w_ph_adv[1];
                r_quad_b <= w_ph_adv[1];
            end
        end
    end

`ifdef QGEN_IRQ_EN
    always_ff @(posedge apb_clock or negedge resetn) begin
        if (!resetn) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_irq_en <= apb_pwdata[4];
            end
            r_irq <= r_done && r_irq_en;
        end
    end
    assign irq = r_irq;
`endif

    // ---------------- read path ----------------
    always_comb begin
        w_rdata = '0;
        case (apb_paddr)
            12'h000: begin
                w_rdata[0] = r_start;
                w_rdata[1] = r_stop_req;
                w_rdata[2] = r_cont;
                w_rdata[3] = r_dir;
`ifdef QGEN_IRQ_EN
                w_rdata[4] = r_irq_en;
`endif
                w_rdata[16 +: DIV_BITS] = r_div;
            end
            12'h004: w_rdata[1:0]          = {r_done, w_busy};
            12'h008: w_rdata[CNT_BITS-1:0] = r_steps;
            12'h00C: w_rdata[CNT_BITS-1:0] = r_pos;
            12'h010: w_rdata[CNT_BITS-1:0] = r_remain;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge apb_clock or negedge resetn) begin
        if (!resetn) begin
            r_prdata <= '0;
        end else if (w_rd_setup) begin
            r_prdata <= w_rdata;
        end
    end

    assign apb_prdata = r_prdata;
    assign quad_a     = r_quad_a;
    assign quad_b     = r_quad_b;
    assign busy       = w_busy;

endmodule

// File: tb/tb_apb_quad_gen.sv
`timescale 1ns/1ps
module tb_apb_quad_gen;

    logic        apb_clock = 1'b0;
    logic        resetn = 1'b0;
    logic        stop = 1'b0;
    logic        apb_psel = 1'b0;
    logic        apb_penable = 1'b0;
    logic        apb_pwrite = 1'b0;
    logic [11:0] apb_paddr = '0;
    logic [31:0] apb_pwdata = '0;
    logic [31:0] apb_prdata;
    logic        quad_a;
    logic        quad_b;
    logic        busy;
`ifdef QGEN_IRQ_EN
    logic        irq;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int t_ref = 0;
    int dec_count = 0;

    typedef struct {
        logic [1:0] ab;
        int         gap;
    } exp_t;

    exp_t       q[$];
    exp_t       m_e;
    logic [1:0] m_ph = 2'd0;
    logic [1:0] prev_ab = 2'b00;
    logic [1:0] cur_ab;
    logic [1:0] m_d;

    apb_quad_gen dut (
        .apb_clock   (apb_clock),
        .resetn      (resetn),
        .stop        (stop),
        .apb_psel    (apb_psel),
        .apb_penable (apb_penable),
        .apb_pwrite  (apb_pwrite),
        .apb_paddr   (apb_paddr),
        .apb_pwdata  (apb_pwdata),
        .apb_prdata  (apb_prdata),
        .quad_a      (quad_a),
        .quad_b      (quad_b),
`ifdef QGEN_IRQ_EN
        .irq         (irq),
`endif
        .busy        (busy)
    );

    always #5 apb_clock = ~apb_clock;

    function automatic logic [1:0] ab_of(input logic [1:0] ph);
        case (ph)
            2'd0:    return 2'b00;
            2'd1:    return 2'b10;
            2'd2:    return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic [1:0] ph_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'd0;
            2'b10:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Edge monitor: every change on {A,B} pops the scoreboard, checks the
    // level and the spacing from the previous edge (or from the start write),
    // and feeds a reference quadrature decoder.
    always @(negedge apb_clock) begin
        cyc++;
        cur_ab = {quad_a, quad_b};
        if (resetn && (cur_ab !== prev_ab)) begin
            n_vec++;
            assert (q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_edge: got %b want no edge", cur_ab);
            end
            if (q.size() != 0) begin
                m_e = q.pop_front();
                n_vec++;
                assert (cur_ab === m_e.ab) else begin
                    n_err++;
                    $error("FAIL edge_level: got %b want %b", cur_ab, m_e.ab);
                end
                if (m_e.gap != 0) begin
                    n_vec++;
                    assert ((cyc - t_ref) === m_e.gap) else begin
                        n_err++;
                        $error("FAIL edge_gap: got %0d want %0d", cyc - t_ref, m_e.gap);
                    end
                end
            end
            m_d = ph_of(cur_ab) - ph_of(prev_ab);
            if (m_d == 2'd1)      dec_count++;
            else if (m_d == 2'd3) dec_count--;
            t_ref   = cyc;
            prev_ab = cur_ab;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        @(posedge apb_clock); #1;
        apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b1;
        apb_paddr = a; apb_pwdata = d;
        @(posedge apb_clock); #1;
        apb_penable = 1'b1;
        @(posedge apb_clock); #1;
        apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
        @(posedge apb_clock); #1;
        apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b0; apb_paddr = a;
        @(posedge apb_clock); #1;
        apb_penable = 1'b1;
        @(posedge apb_clock); #1;
        apb_psel = 1'b0; apb_penable = 1'b0;
        d = apb_prdata;
    endtask

    task automatic check_reg(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(a, d);
        check(tag, d, exp);
    endtask

    // Push one expected edge: advance the model phase and record the level.
    task automatic push_one(input bit rev, input int gap);
        exp_t e;
        m_ph  = rev ? (m_ph - 2'd1) : (m_ph + 2'd1);
        e.ab  = ab_of(m_ph);
        e.gap = gap;
        q.push_back(e);
    endtask

    // First edge lands div+3 monitor cycles after the start write returns
    // (commit, IDLE->RUN, then div+1 clocks); later edges every div+1.
    task automatic push_run(input int n, input bit rev, input int div);
        for (int i = 0; i < n; i++) push_one(rev, (i == 0) ? div + 3 : div + 1);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        repeat (2) @(negedge apb_clock);
        while (busy && k < 2000) begin
            @(negedge apb_clock);
            k++;
        end
        repeat (2) @(negedge apb_clock);
        check({tag, "_idle"}, {31'b0, busy}, 32'h0);
        check({tag, "_edges_left"}, 32'(q.size()), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dec_before;

        // ---- reset ----
        repeat (2) @(negedge apb_clock);
        check("rst_busy",   {31'b0, busy}, 32'h0);
        check("rst_quad",   {30'b0, quad_a, quad_b}, 32'h0);
        check("rst_prdata", apb_prdata, 32'h0);
        @(posedge apb_clock); #1;
        resetn = 1'b1;
        check_reg("rst_ctrl",   12'h000, 32'h0);
        check_reg("rst_stat",   12'h004, 32'h0);
        check_reg("rst_steps",  12'h008, 32'h0);
        check_reg("rst_pos",    12'h00C, 32'h0);
        check_reg("rst_remain", 12'h010, 32'h0);
        apb_write(12'h014, 32'hFFFF_FFFF);
        check_reg("unmapped",   12'h014, 32'h0);

        // ---- 8 forward edges, div=3 ----
        apb_write(12'h008, 32'd8);
        push_run(8, 1'b0, 3);
        apb_write(12'h000, 32'h0003_0001);
        t_ref = cyc;
        wait_idle("fwd8");
        check_reg("fwd8_pos",    12'h00C, 32'd8);
        check_reg("fwd8_stat",   12'h004, 32'h2);
        check_reg("fwd8_remain", 12'h010, 32'h0);
        check_reg("fwd8_ctrl",   12'h000, 32'h0003_0000);

        // ---- 5 reverse edges, decoder must count -5 ----
        apb_write(12'h008, 32'd5);
        push_run(5, 1'b1, 3);
        dec_before = dec_count;
        apb_write(12'h000, 32'h0003_0009);
        t_ref = cyc;
        wait_idle("rev5");
        check_reg("rev5_pos", 12'h00C, 32'd3);
        check("rev5_decoder", 32'(dec_count - dec_before), 32'(-5));

        // ---- stop_req after 10 of 100 edges, div=0 ----
        apb_write(12'h004, 32'h0);
        check_reg("done_clear", 12'h004, 32'h0);
        apb_write(12'h008, 32'd100);
        push_run(10, 1'b0, 0);
        apb_write(12'h000, 32'h0000_0001);
        t_ref = cyc;
        repeat (8) @(posedge apb_clock);
        apb_write(12'h000, 32'h0000_0002);
        check("abort_busy_before", {31'b0, busy}, 32'h1);
        @(posedge apb_clock); #1;
        check("abort_busy_after",  {31'b0, busy}, 32'h0);
        repeat (10) @(negedge apb_clock);
        check("abort_hold",   {30'b0, quad_a, quad_b}, 32'h2);
        check("abort_edges",  32'(q.size()), 32'h0);
        check_reg("abort_remain", 12'h010, 32'd90);
        check_reg("abort_stat",   12'h004, 32'h0);
        check_reg("abort_pos",    12'h00C, 32'd13);
        check_reg("abort_ctrl",   12'h000, 32'h0);

        // ---- continuous, div=1, debug stop held 20 cycles ----
        apb_write(12'h008, 32'd4);
        push_one(1'b0, 4);
        push_one(1'b0, 2);
        push_one(1'b0, 22);
        push_one(1'b0, 2);
        push_one(1'b0, 2);
        apb_write(12'h000, 32'h0001_0005);
        t_ref = cyc;
        repeat (6) @(posedge apb_clock); #1;
        stop = 1'b1;
        repeat (20) @(posedge apb_clock); #1;
        stop = 1'b0;
        repeat (3) @(posedge apb_clock);
        apb_write(12'h000, 32'h0000_0002);
        repeat (4) @(negedge apb_clock);
        check("cont_busy",  {31'b0, busy}, 32'h0);
        check("cont_edges", 32'(q.size()), 32'h0);
        check_reg("cont_remain", 12'h010, 32'd3);
        check_reg("cont_pos",    12'h00C, 32'd18);
        check_reg("cont_stat",   12'h004, 32'h0);

        // ---- STEPS=0: no edges, immediate done ----
        apb_write(12'h008, 32'd0);
        apb_write(12'h000, 32'h0000_0011);
        check_reg("zero_stat", 12'h004, 32'h2);
`ifdef QGEN_IRQ_EN
        check_reg("zero_ctrl", 12'h000, 32'h10);
        check("irq_set", {31'b0, irq}, 32'h1);
`else
        check_reg("zero_ctrl", 12'h000, 32'h0);
`endif
        apb_write(12'h004, 32'h0);
        check_reg("zero_clear", 12'h004, 32'h0);
`ifdef QGEN_IRQ_EN
        check("irq_clr", {31'b0, irq}, 32'h0);
`endif
        check("zero_edges", 32'(q.size()), 32'h0);

        // ---- POS wrap from -1 forward by one edge ----
        apb_write(12'h00C, 32'hFFFF_FFFF);
        check_reg("pos_rw", 12'h00C, 32'hFFFF_FFFF);
        apb_write(12'h008, 32'd1);
        push_run(1, 1'b0, 0);
        apb_write(12'h000, 32'h0000_0001);
        t_ref = cyc;
        wait_idle("wrap");
        check_reg("wrap_pos",  12'h00C, 32'h0);
        check_reg("wrap_stat", 12'h004, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
